fifo_dual_reader: RTL and testbench

Read-side controller for the two-consumer tagged FIFO: watches the per-consumer `empty[1:0]` flags, issues one-hot `rd[1:0]` pulses, captures the returned word from `dataout`, and delivers it to one of two downstream sinks over a valid/ready handshake. Bit 7 of each word is the destination tag and is stripped on delivery. The block arbitrates round-robin between the two consumers, never over-reads, and flags tag mismatches.

---
 rtl/fifo_dual_reader_if.sv | 23 ++
 rtl/fifo_dual_reader.sv | 63 ++++++
 tb/tb_fifo_dual_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_dual_reader_if.sv
// fifo_dual_reader_if: FIFO read port, sink handshakes and status of the dual reader
interface fifo_dual_reader_if #(
   parameter int DW = 8,
   parameter int CW = 16
);
   logic          en;
   logic [1:0]    empty;
   logic [1:0]    rd;
   logic [DW-1:0] dataout;
   logic [DW-2:0] m0_data, m1_data;
   logic          m0_valid, m1_valid;
   logic          m0_ready, m1_ready;
   logic          tag_err;
   logic [CW-1:0] words0, words1;
   modport master (
      input  en, empty, dataout, m0_ready, m1_ready,
      output rd, m0_data, m1_data, m0_valid, m1_valid, tag_err, words0, words1
   );
   modport slave (
      output en, empty, dataout, m0_ready, m1_ready,
      input  rd, m0_data, m1_data, m0_valid, m1_valid, tag_err, words0, words1
   );
endinterface

// File: rtl/fifo_dual_reader.sv
// fifo_dual_reader: round-robin reader for a two-consumer tagged FIFO feeding two valid/ready sinks
module fifo_dual_reader #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input logic                ck,
   input logic                rst,
   fifo_dual_reader_if.master bus
);
   logic [1:0]              rd_q, rd_d, cap_q, cap_d;
   logic [1:0]              elig, grant, ready, pop, push;
   logic [1:0][1:0]         cnt_q, cnt_d, widx;
   logic [1:0][1:0][DW-2:0] buf_q, buf_d;
   logic [1:0][CW-1:0]      words_q, words_d;
   logic                    ptr_q, ptr_d, tag_err_q, tag_err_d;
   always_comb begin
      ready = {bus.m1_ready, bus.m0_ready};
      tag_err_d = tag_err_q;
      for (int c = 0; c < 2; c++) begin
         // an outstanding rd blocks the channel, so only buffered and captured words need slots
         elig[c] = bus.en && !bus.empty[c] && !rd_q[c] && ((cnt_q[c] + {1'b0, cap_q[c]}) < 2'd2);
         pop[c] = (cnt_q[c] != 2'd0) && ready[c];
         push[c] = cap_q[c];
         widx[c] = cnt_q[c] - {1'b0, pop[c]};
         cnt_d[c] = widx[c] + {1'b0, push[c]};
         words_d[c] = words_q[c] + CW'(pop[c]);
         buf_d[c][0] = (push[c] && widx[c] == 2'd0) ? bus.dataout[DW-2:0] : pop[c] ? buf_q[c][1] : buf_q[c][0];
         buf_d[c][1] = (push[c] && widx[c] == 2'd1) ? bus.dataout[DW-2:0] : buf_q[c][1];
         tag_err_d = tag_err_d || (cap_q[c] && (bus.dataout[DW-1] != c[0]));
      end
      grant = (elig == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : elig;
      ptr_d = grant[0] ? 1'b1 : grant[1] ? 1'b0 : ptr_q;
      rd_d = grant;
      cap_d = rd_q;
   end
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         rd_q      <= '0;
         cap_q     <= '0;
         cnt_q     <= '0;
         buf_q     <= '0;
         words_q   <= '0;
         ptr_q     <= 1'b0;
         tag_err_q <= 1'b0;
      end else begin
         rd_q      <= rd_d;
         cap_q     <= cap_d;
         cnt_q     <= cnt_d;
         buf_q     <= buf_d;
         words_q   <= words_d;
         ptr_q     <= ptr_d;
         tag_err_q <= tag_err_d;
      end
   end
   assign bus.rd       = rd_q;
   assign bus.m0_data  = buf_q[0][0];
   assign bus.m1_data  = buf_q[1][0];
   assign bus.m0_valid = cnt_q[0] != 2'd0;
   assign bus.m1_valid = cnt_q[1] != 2'd0;
   assign bus.tag_err  = tag_err_q;
   assign bus.words0   = words_q[0];
   assign bus.words1   = words_q[1];
endmodule

// File: tb/tb_fifo_dual_reader.sv
// tb_fifo_dual_reader: directed checks of the dual reader against a small two-consumer FIFO model
module tb_fifo_dual_reader;
   logic ck, rst;
   int n_chk, n_fail;
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   logic [3:0] rp0, rp1, wp0, wp1;
   logic [6:0] got0 [$];
   logic [6:0] got1 [$];
   int b0, b1, n;
   fifo_dual_reader_if bus ();
   fifo_dual_reader dut (.ck(ck), .rst(rst), .bus(bus));
   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end
   assign bus.empty = {rp1 == wp1, rp0 == wp0};
   always @(posedge ck or posedge rst) begin
      if (rst) begin
         rp0 <= '0;
         rp1 <= '0;
         bus.dataout <= '0;
      end else if (bus.rd[0]) begin
         bus.dataout <= mem0[rp0];
         rp0 <= rp0 + 4'd1;
      end else if (bus.rd[1]) begin
         bus.dataout <= mem1[rp1];
         rp1 <= rp1 + 4'd1;
      end
   end
   always @(posedge ck) begin
      if (bus.m0_valid && bus.m0_ready) got0.push_back(bus.m0_data);
      if (bus.m1_valid && bus.m1_ready) got1.push_back(bus.m1_data);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick(input int k);
      repeat (k) begin
         @(negedge ck);
         check("rd_onehot", {31'b0, bus.rd != 2'b11}, 1);
         check("cnt_bound", {31'b0, (dut.cnt_q[0] <= 2'd2) && (dut.cnt_q[1] <= 2'd2)}, 1);
      end
   endtask
   task automatic do_reset();
      @(negedge ck);
      rst = 1'b1;
      bus.en = 1'b0;
      bus.m0_ready = 1'b0;
      bus.m1_ready = 1'b0;
      wp0 = '0;
      wp1 = '0;
      tick(1);
      rst = 1'b0;
   endtask
   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.m0_ready = 1'b0;
      bus.m1_ready = 1'b0;
      wp0 = '0;
      wp1 = '0;
      tick(2);
      check("rst_rd", bus.rd, 0);
      check("rst_valid", {bus.m1_valid, bus.m0_valid}, 0);
      check("rst_data", {bus.m1_data, bus.m0_data}, 0);
      check("rst_tag_err", bus.tag_err, 0);
      check("rst_words", {bus.words1, bus.words0}, 0);
      // single consumer, two words, sink always ready
      mem0[0] = 8'h01; mem0[1] = 8'h02; wp0 = 4'd2;
      bus.m0_ready = 1'b1;
      bus.en = 1'b1;
      rst = 1'b0;
      b0 = got0.size();
      tick(1); check("t1_rd1", bus.rd, 2'b01);
      tick(1); check("t1_rd2", bus.rd, 2'b00);
      tick(1); check("t1_rd3", bus.rd, 2'b01);
      check("t1_valid", bus.m0_valid, 1);
      check("t1_data1", bus.m0_data, 7'h01);
      tick(2); check("t1_data2", bus.m0_data, 7'h02);
      tick(1); check("t1_words0", bus.words0, 2);
      check("t1_tag_err", bus.tag_err, 0);
      check("t1_order0", got0[b0], 7'h01);
      check("t1_order1", got0[b0+1], 7'h02);
      // both consumers active: alternating reads
      do_reset();
      mem0[0] = 8'h11; mem0[1] = 8'h12; mem0[2] = 8'h13; wp0 = 4'd3;
      mem1[0] = 8'hA1; mem1[1] = 8'hA2; mem1[2] = 8'hA3; wp1 = 4'd3;
      bus.m0_ready = 1'b1;
      bus.m1_ready = 1'b1;
      bus.en = 1'b1;
      b0 = got0.size();
      b1 = got1.size();
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("t2_alt_rd", bus.rd, i[0] ? 2'b10 : 2'b01);
      end
      tick(6);
      check("t2_n0", got0.size() - b0, 3);
      check("t2_n1", got1.size() - b1, 3);
      for (int i = 0; i < 3; i++) begin
         check("t2_order0", got0[b0+i], 32'h11 + i);
         check("t2_order1", got1[b1+i], 32'h21 + i);
      end
      check("t2_words", {bus.words1, bus.words0}, {16'd3, 16'd3});
      check("t2_tag_err", bus.tag_err, 0);
      // sink 1 back-pressure with five queued words
      do_reset();
      for (int i = 0; i < 5; i++) mem1[i] = 8'h81 + 8'(i);
      wp1 = 4'd5;
      bus.en = 1'b1;
      b1 = got1.size();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         n += int'(bus.rd[1]);
      end
      check("t3_bp_reads", n, 2);
      check("t3_valid", bus.m1_valid, 1);
      check("t3_head", bus.m1_data, 7'h01);
      bus.m1_ready = 1'b1;
      tick(16);
      check("t3_n1", got1.size() - b1, 5);
      for (int i = 0; i < 5; i++) check("t3_order1", got1[b1+i], 32'h01 + i);
      check("t3_words1", bus.words1, 5);
      // tag mismatch on channel 0
      do_reset();
      mem0[0] = 8'h85; wp0 = 4'd1;
      bus.m0_ready = 1'b1;
      bus.en = 1'b1;
      b0 = got0.size();
      tick(1); check("t4_rd", bus.rd, 2'b01);
      tick(1); check("t4_tag_before", bus.tag_err, 0);
      tick(1); check("t4_tag_set", bus.tag_err, 1);
      check("t4_data", bus.m0_data, 7'h05);
      tick(3); check("t4_tag_sticky", bus.tag_err, 1);
      check("t4_delivered", got0[b0], 7'h05);
      check("t4_words0", bus.words0, 1);
      // exactly one word left in consumer 1
      do_reset();
      mem1[0] = 8'h9F; wp1 = 4'd1;
      bus.m1_ready = 1'b1;
      bus.en = 1'b1;
      b1 = got1.size();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (bus.rd != 2'b00) n++;
         if (i == 1) check("t5_no_reread", bus.rd, 2'b00);
      end
      check("t5_reads", n, 1);
      check("t5_data", got1[b1], 7'h1F);
      check("t5_words1", bus.words1, 1);
      // en low stops new reads
      mem1[1] = 8'h90; wp1 = 4'd2;
      bus.en = 1'b0;
      tick(4); check("t5_en_low", bus.rd, 2'b00);
      // reset with a read in flight and both buffers holding data
      do_reset();
      for (int i = 0; i < 4; i++) begin
         mem0[i] = 8'h01 + 8'(i);
         mem1[i] = 8'h81 + 8'(i);
      end
      wp0 = 4'd4; wp1 = 4'd4;
      bus.en = 1'b1;
      tick(4);
      check("t6_pre_rd", bus.rd, 2'b10);
      check("t6_pre_valid", {bus.m1_valid, bus.m0_valid}, 2'b11);
      rst = 1'b1;
      #1;
      check("t6_rd", bus.rd, 0);
      check("t6_valid", {bus.m1_valid, bus.m0_valid}, 0);
      check("t6_data", {bus.m1_data, bus.m0_data}, 0);
      check("t6_tag_err", bus.tag_err, 0);
      wp0 = 4'd2; wp1 = 4'd2;
      tick(1);
      rst = 1'b0;
      tick(1); check("t6_first_grant", bus.rd, 2'b01);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
